exception_ctrl: RTL and testbench

Parametrised multi-source exception controller for the single-cycle LEGv8 datapath. It replaces the single-source exception path with NSRC prioritised, maskable request lines, plus explicit ELR/ESR/EMASK system registers with a software read/write port. It sequences entry to and return from the handler through a small state machine. It sits beside fetch: it drives the PC redirect (EProc/EVAddr) and supplies readData3 to execute.

---
 rtl/exception_ctrl.sv | 133 +++++++++++++
 tb/tb_exception_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: prioritised, maskable multi-source exception controller.
// It sequences handler entry and return with a four-state machine
// (IDLE -> TAKE -> HANDLER -> RET -> IDLE). It also holds the ELR, ESR and
// EMASK system registers behind a software read/write port.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   ExcReq[NSRC]         level request lines, bit i reports code i+1
//   ERet                 return-from-exception seen this cycle
//   PCSrc                branch taken this cycle
//   NextPC_F             PC+4 of the current instruction
//   PCBranch_E           branch target of the current instruction
//   sr_we/sr_sel/sr_wdata  system-register write port (0 ELR, 1 ESR, 2 EMASK)
//   EProc, EVAddr_F      fetch redirect request and target
//   ExcAck               one-cycle pulse in the entry (TAKE) cycle
//   InHandler            high in TAKE and HANDLER
//   readData3_E          selected system register, zero-extended
module exception_ctrl #(
  parameter int             N       = 64,
  parameter int             NSRC    = 4,
  parameter logic [N-1:0]   VBASE   = N'('hD8),
  parameter logic [N-1:0]   VSTRIDE = N'(8)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] ExcReq,
  input  logic            ERet,
  input  logic            PCSrc,
  input  logic [N-1:0]    NextPC_F,
  input  logic [N-1:0]    PCBranch_E,
  input  logic            sr_we,
  input  logic [1:0]      sr_sel,
  input  logic [N-1:0]    sr_wdata,
  output logic            EProc,
  output logic [N-1:0]    EVAddr_F,
  output logic            ExcAck,
  output logic            InHandler,
  output logic [N-1:0]    readData3_E
);

  typedef enum logic [1:0] {IDLE, TAKE, HANDLER, RET} state_t;

  state_t          state, state_nx;
  logic [NSRC-1:0] pending, emask;
  logic [N-1:0]    elr;
  logic [3:0]      esr;

  logic [NSRC-1:0] elig, win_oh;
  logic [3:0]      win_code;
  logic            take;

  // Lowest eligible index wins. The one-hot form clears pending; the code
  // goes into ESR.
  assign elig   = pending & emask;
  assign win_oh = elig & (~elig + NSRC'(1));

  always_comb begin
    win_code = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) win_code = 4'(i + 1);
  end

  always_comb begin
    state_nx    = state;
    take        = 1'b0;
    EProc       = 1'b0;
    EVAddr_F    = '0;
    ExcAck      = 1'b0;
    InHandler   = 1'b0;
    case (state)
      IDLE: if (|elig) begin
        state_nx = TAKE;
        take     = 1'b1;
      end
      TAKE: begin
        state_nx  = HANDLER;
        EProc     = 1'b1;
        EVAddr_F  = VBASE + N'(esr) * VSTRIDE;
        ExcAck    = 1'b1;
        InHandler = 1'b1;
      end
      HANDLER: begin
        InHandler = 1'b1;
        if (ERet) state_nx = RET;
      end
      RET: begin
        state_nx = IDLE;
        EProc    = 1'b1;
        EVAddr_F = elr;
      end
      default: state_nx = IDLE;
    endcase
    // Hold outputs quiet while reset is asserted, even before the first edge.
    if (!reset) begin
      EProc     = 1'b0;
      EVAddr_F  = '0;
      ExcAck    = 1'b0;
      InHandler = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      elr     <= '0;
      esr     <= '0;
      emask   <= '1;
    end else begin
      state   <= state_nx;
      pending <= (pending | ExcReq) & ~(take ? win_oh : '0);
      // An entry capture takes priority over a software ELR/ESR write.
      if (take) begin
        elr <= PCSrc ? PCBranch_E : NextPC_F;
        esr <= win_code;
      end else if (sr_we) begin
        if (sr_sel == 2'd0) elr <= sr_wdata;
        if (sr_sel == 2'd1) esr <= sr_wdata[3:0];
      end
      if (sr_we && sr_sel == 2'd2) emask <= sr_wdata[NSRC-1:0];
    end
  end

  always_comb begin
    case (sr_sel)
      2'd0:    readData3_E = elr;
      2'd1:    readData3_E = N'(esr);
      2'd2:    readData3_E = N'(emask);
      default: readData3_E = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;
  localparam int N = 64;
  localparam int NSRC = 4;
  localparam logic [63:0] VBASE = 64'hD8;
  localparam logic [63:0] VSTRIDE = 64'd8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] ExcReq;
  logic            ERet, PCSrc, sr_we;
  logic [N-1:0]    NextPC_F, PCBranch_E, sr_wdata;
  logic [1:0]      sr_sel;
  logic            EProc, ExcAck, InHandler;
  logic [N-1:0]    EVAddr_F, readData3_E;

  exception_ctrl #(.N(N), .NSRC(NSRC), .VBASE(VBASE), .VSTRIDE(VSTRIDE)) dut (
    .clk(clk), .reset(reset), .ExcReq(ExcReq), .ERet(ERet), .PCSrc(PCSrc),
    .NextPC_F(NextPC_F), .PCBranch_E(PCBranch_E), .sr_we(sr_we),
    .sr_sel(sr_sel), .sr_wdata(sr_wdata), .EProc(EProc), .EVAddr_F(EVAddr_F),
    .ExcAck(ExcAck), .InHandler(InHandler), .readData3_E(readData3_E)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. The exception sequence is tracked as "cycles since
  // entry": 0 = not in an exception, 1 = entry cycle, 2 = inside the
  // handler waiting for ERet, 3 = the return cycle.
  int          m_phase;
  bit [3:0]    m_pend, m_mask, m_esr;
  bit [63:0]   m_elr;

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic m_step();
    int w;
    bit [3:0] nxt_pend;
    if (!reset) begin
      m_phase = 0; m_pend = 0; m_mask = 4'hF; m_esr = 0; m_elr = 0;
      return;
    end
    nxt_pend = m_pend | ExcReq;
    w = lowest(m_pend & m_mask);
    if (m_phase == 0 && w >= 0) begin
      m_elr = PCSrc ? PCBranch_E : NextPC_F;
      m_esr = 4'(w + 1);
      nxt_pend[w] = 1'b0;
      m_phase = 1;
    end else begin
      if (sr_we && sr_sel == 0) m_elr = sr_wdata;
      if (sr_we && sr_sel == 1) m_esr = sr_wdata[3:0];
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && ERet) m_phase = 3;
      else if (m_phase == 3) m_phase = 0;
    end
    if (sr_we && sr_sel == 2) m_mask = sr_wdata[3:0];
    m_pend = nxt_pend;
  endtask

  task automatic check_outputs();
    bit on = (reset === 1'b1);
    bit [63:0] va = 0, rd = 0;
    if (on && m_phase == 1) va = VBASE + 64'(m_esr) * VSTRIDE;
    if (on && m_phase == 3) va = m_elr;
    case (sr_sel)
      2'd0: rd = m_elr;
      2'd1: rd = 64'(m_esr);
      2'd2: rd = 64'(m_mask);
      default: rd = 0;
    endcase
    chk("EProc", 64'(EProc), 64'(on && (m_phase == 1 || m_phase == 3)));
    chk("ExcAck", 64'(ExcAck), 64'(on && m_phase == 1));
    chk("InHandler", 64'(InHandler), 64'(on && (m_phase == 1 || m_phase == 2)));
    chk("EVAddr_F", EVAddr_F, va);
    chk("readData3_E", readData3_E, rd);
  endtask

  task automatic drive_random(input int req_bias);
    reset      = ($urandom_range(0, 199) != 0);
    ExcReq     = '0;
    for (int i = 0; i < NSRC; i++)
      if ($urandom_range(0, req_bias) == 0) ExcReq[i] = 1'b1;
    ERet       = ($urandom_range(0, 2) == 0);
    PCSrc      = $urandom_range(0, 1) == 1;
    NextPC_F   = {$urandom, $urandom};
    PCBranch_E = {$urandom, $urandom};
    sr_sel     = 2'($urandom_range(0, 3));
    sr_we      = ($urandom_range(0, 9) == 0);
    sr_wdata   = {$urandom, $urandom};
    // Keep mask writes mostly permissive so entries keep happening.
    if (sr_we && sr_sel == 2 && $urandom_range(0, 1) == 1) sr_wdata[3:0] = 4'hF;
  endtask

  initial begin
    reset = 1'b0; ExcReq = '0; ERet = 0; PCSrc = 0; NextPC_F = '0;
    PCBranch_E = '0; sr_we = 0; sr_sel = 2'd2; sr_wdata = '0;
    @(negedge clk);
    chk("EProc_in_reset", 64'(EProc), 64'd0);
    chk("ExcAck_in_reset", 64'(ExcAck), 64'd0);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      check_outputs();
      drive_random(c < 2000 ? 9 : 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
